tge_tx_packetizer: RTL and testbench
====================================

Name: tge_tx_packetizer

Overview:
- Converts a continuous 64-bit sample stream into fixed-length UDP payload frames for the 10GbE core's fabric transmit interface.
- Drives tx_valid/tx_data/tx_end_of_frame/tx_dest_ip/tx_dest_port and honours the core's tx_afull back-pressure.
- Buffers input in an internal FIFO and prepends a sequence-number header word to every frame.
- Sits between the DSP output and the ten-gig Ethernet core, in the core's fabric clock domain.

Parameters:
PAYLOAD_WORDS, 128, 64-bit payload words per frame (1..2**FIFO_AW).
FIFO_AW, 9, input FIFO address width; depth is 2**FIFO_AW words.
HDR_MAGIC, 8'h5A, value placed in header bits [63:56].

Ports:
clk  in  1  fabric clock, shared with the Ethernet core's clk
rst_n  in  1  asynchronous active-low reset
enable  in  1  permits new frames to start
dest_ip  in  32  destination IP; sampled at frame start
dest_port  in  16  destination UDP port; sampled at frame start
in_valid  in  1  input word valid
in_data  in  64  input sample word
in_ready  out  1  FIFO not full
tx_valid  out  1  to core: word valid
tx_data  out  64  to core: frame word
tx_end_of_frame  out  1  to core: last word of frame
tx_dest_ip  out  32  to core: held for the whole frame
tx_dest_port  out  16  to core: held for the whole frame
tx_afull  in  1  from core: TX buffer almost full
tx_overflow  in  1  from core: TX buffer overflowed
pkt_count  out  32  frames fully sent; wraps
drop_count  out  32  input words lost (in_valid & !in_ready); saturates at all-ones
core_ovf  out  1  sticky; set by tx_overflow

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: tx_valid=0, tx_end_of_frame=0, tx_data=0, tx_dest_ip=0, tx_dest_port=0, pkt_count=0, drop_count=0, core_ovf=0.
  - Internal: FIFO flushed, seq=0, FSM=IDLE.
  - in_ready=0 while reset is asserted; in_ready=1 from the first clock after release.
- FIFO write:
  - Occurs on in_valid & in_ready.
  - in_ready = (fill < 2**FIFO_AW).
  - A word offered while full is discarded and drop_count increments.
  - Simultaneous read and write at full: the write is still refused (in_ready computed from the registered fill).
- FSM states IDLE, HEADER, PAYLOAD. All tx_* outputs are registered. A "launch" means the word appears on tx_* on the next clock edge.
- IDLE -> HEADER:
  - Condition: enable=1, fill >= PAYLOAD_WORDS, tx_afull=0.
  - dest_ip and dest_port are latched into tx_dest_ip and tx_dest_port.
- HEADER:
  - When tx_afull=0, launch header word {HDR_MAGIC, 8'h00, seq[47:0]}, then go to PAYLOAD with word counter=0.
  - When tx_afull=1, launch nothing (tx_valid=0) and stay in HEADER.
- PAYLOAD:
  - Each cycle with tx_afull=0, pop one FIFO word, launch it, and increment the counter.
  - With tx_afull=1, tx_valid=0 and nothing is popped.
  - On the word with counter = PAYLOAD_WORDS-1: assert tx_end_of_frame with it, then go to IDLE, increment seq (48-bit, wraps to 0) and increment pkt_count.
- Frame length is PAYLOAD_WORDS+1 tx_valid cycles. The FIFO cannot underflow mid-frame because the full payload is resident at frame start.
- tx_valid and tx_end_of_frame are single-cycle per word. tx_end_of_frame is only ever asserted together with tx_valid.
- tx_dest_ip and tx_dest_port are constant from the header through end_of_frame. Changes to dest_ip or dest_port mid-frame affect only the next frame.
- Deasserting enable mid-frame completes the current frame, then remains in IDLE. The FIFO keeps filling.
- Back-to-back frames: the earliest next header launches 2 cycles after the end_of_frame launch (one IDLE cycle).
- tx_overflow=1 on any edge sets core_ovf. It clears only on reset.

Test Plan:
1. PAYLOAD_WORDS=4, FIFO_AW=3, enable=1, dest 0xC0A80510:10000, write 1..4 -> one frame: header 0x5A00_0000_0000_0000, then 1,2,3,4; eof with 4; tx_dest stable; pkt_count=1.
2. Write 1..8 continuously -> two frames; second header seq=1; exactly one idle cycle between eof and second header; pkt_count=2.
3. Hold tx_afull=1 for 3 cycles after payload word 2 -> tx_valid low exactly 3 cycles; remaining words 3,4 follow in order; no word lost or duplicated.
4. enable=0, write 10 words into 8-deep FIFO -> in_ready low after 8; drop_count=2; enable=1 -> frames carry words 1..4 then 5..8.
5. Pulse rst_n low during payload word 2 -> tx_valid=0 immediately; after release, seq=0, pkt_count=0, FIFO empty; next full frame header seq=0.
6. Pulse tx_overflow one cycle -> core_ovf=1 and stays set through subsequent frames until reset.

Source files
------------

// File: rtl/tge_tx_packetizer.sv
// tge_tx_packetizer
//   Packs a continuous 64-bit sample stream into fixed-length UDP payload
//   frames for the 10GbE core fabric TX interface. Each frame is a header word
//   {HDR_MAGIC, 8'h00, seq[47:0]} followed by PAYLOAD_WORDS payload words
//   taken from an internal FIFO. A frame only starts once its whole payload is
//   resident, so the FIFO cannot underflow mid-frame.
// Ports:
//   clk, rst_n                     fabric clock, async active-low reset
//   enable                         permits new frames to start
//   dest_ip, dest_port             destination, sampled at frame start
//   in_valid, in_data, in_ready    sample input (in_ready = FIFO not full)
//   tx_valid, tx_data, tx_end_of_frame, tx_dest_ip, tx_dest_port
//                                  registered outputs to the Ethernet core
//   tx_afull, tx_overflow          core back-pressure / overflow flags
//   pkt_count                      frames fully sent (wraps)
//   drop_count                     input words refused while full (saturates)
//   core_ovf                       sticky copy of tx_overflow
module tge_tx_packetizer #(
  parameter int         PAYLOAD_WORDS = 128,
  parameter int         FIFO_AW       = 9,
  parameter logic [7:0] HDR_MAGIC     = 8'h5A
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [31:0] dest_ip,
  input  logic [15:0] dest_port,
  input  logic        in_valid,
  input  logic [63:0] in_data,
  output logic        in_ready,
  output logic        tx_valid,
  output logic [63:0] tx_data,
  output logic        tx_end_of_frame,
  output logic [31:0] tx_dest_ip,
  output logic [15:0] tx_dest_port,
  input  logic        tx_afull,
  input  logic        tx_overflow,
  output logic [31:0] pkt_count,
  output logic [31:0] drop_count,
  output logic        core_ovf
);

  localparam int DEPTH = 2**FIFO_AW;
  localparam int FW    = FIFO_AW + 1;
  localparam int CW    = $clog2(PAYLOAD_WORDS + 1);

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [47:0]         seq_q;
  logic [FW-1:0]       fill_q;
  logic [FIFO_AW-1:0]  wr_ptr, rd_ptr;
  logic [63:0]         mem [DEPTH];
  logic                rst_done;
  logic                wr, pop, launch, launch_eof, latch_dest, frame_done;
  logic [63:0]         launch_data;

  // rst_done holds in_ready low until the first clock after reset release.
  assign in_ready = rst_done && (fill_q < FW'(DEPTH));
  assign wr       = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pop         = 1'b0;
    launch      = 1'b0;
    launch_eof  = 1'b0;
    launch_data = '0;
    latch_dest  = 1'b0;
    frame_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && fill_q >= FW'(PAYLOAD_WORDS) && !tx_afull) begin
          state_d    = HEADER;
          latch_dest = 1'b1;
        end
      end
      HEADER: begin
        if (!tx_afull) begin
          launch      = 1'b1;
          launch_data = {HDR_MAGIC, 8'h00, seq_q};
          state_d     = PAYLOAD;
          cnt_d       = '0;
        end
      end
      PAYLOAD: begin
        if (!tx_afull) begin
          pop         = 1'b1;
          launch      = 1'b1;
          launch_data = mem[rd_ptr];
          cnt_d       = cnt_q + CW'(1);
          if (cnt_q == CW'(PAYLOAD_WORDS - 1)) begin
            launch_eof = 1'b1;
            frame_done = 1'b1;
            state_d    = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO storage needs no reset; flushing is done through the pointers.
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      seq_q           <= '0;
      fill_q          <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      rst_done        <= 1'b0;
      tx_valid        <= 1'b0;
      tx_end_of_frame <= 1'b0;
      tx_data         <= '0;
      tx_dest_ip      <= '0;
      tx_dest_port    <= '0;
      pkt_count       <= '0;
      drop_count      <= '0;
      core_ovf        <= 1'b0;
    end else begin
      rst_done        <= 1'b1;
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      tx_valid        <= launch;
      tx_end_of_frame <= launch_eof;
      if (launch) tx_data <= launch_data;
      if (latch_dest) begin
        tx_dest_ip   <= dest_ip;
        tx_dest_port <= dest_port;
      end
      if (wr)  wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop) rd_ptr <= rd_ptr + FIFO_AW'(1);
      fill_q <= fill_q + FW'(wr) - FW'(pop);
      if (frame_done) begin
        seq_q     <= seq_q + 48'd1;
        pkt_count <= pkt_count + 32'd1;
      end
      if (in_valid && !in_ready && drop_count != '1)
        drop_count <= drop_count + 32'd1;
      if (tx_overflow) core_ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tge_tx_packetizer.sv
// Scoreboard bench for tge_tx_packetizer (PAYLOAD_WORDS=4, 8-deep FIFO).
module tb_tge_tx_packetizer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] dest_ip = '0;
  logic [15:0] dest_port = '0;
  logic        in_valid = 1'b0;
  logic [63:0] in_data = '0;
  logic        in_ready;
  logic        tx_valid;
  logic [63:0] tx_data;
  logic        tx_end_of_frame;
  logic [31:0] tx_dest_ip;
  logic [15:0] tx_dest_port;
  logic        tx_afull = 1'b0;
  logic        tx_overflow = 1'b0;
  logic [31:0] pkt_count;
  logic [31:0] drop_count;
  logic        core_ovf;

  tge_tx_packetizer #(.PAYLOAD_WORDS(4), .FIFO_AW(3), .HDR_MAGIC(8'h5A)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .dest_ip(dest_ip),
    .dest_port(dest_port), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_end_of_frame(tx_end_of_frame), .tx_dest_ip(tx_dest_ip),
    .tx_dest_port(tx_dest_port), .tx_afull(tx_afull),
    .tx_overflow(tx_overflow), .pkt_count(pkt_count),
    .drop_count(drop_count), .core_ovf(core_ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] data;
    logic        eof;
    logic [31:0] ip;
    logic [15:0] port;
    logic        hdr;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   last_eof_cyc = -100;
  int   hdr_gap = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: every presented word must match the head of the scoreboard.
  always @(negedge clk) begin
    cyc++;
    if (rst_n && tx_end_of_frame && !tx_valid) chk("eof_without_valid", 0, 1);
    if (rst_n && tx_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_word", tx_data, 64'hx);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("tx_data", tx_data, e.data);
        chk("tx_eof", 64'(tx_end_of_frame), 64'(e.eof));
        chk("tx_dest_ip", 64'(tx_dest_ip), 64'(e.ip));
        chk("tx_dest_port", 64'(tx_dest_port), 64'(e.port));
        if (e.hdr) hdr_gap = cyc - last_eof_cyc;
        if (e.eof) last_eof_cyc = cyc;
      end
    end
  end

  task automatic exp_frame(input logic [47:0] s, input logic [63:0] first,
                           input logic [31:0] ip, input logic [15:0] port);
    sb.push_back('{{8'h5A, 8'h00, s}, 1'b0, ip, port, 1'b1});
    for (int i = 0; i < 4; i++)
      sb.push_back('{first + 64'(i), (i == 3), ip, port, 1'b0});
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; tx_afull = 1'b0; tx_overflow = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 0);
    chk("rst_outputs", {tx_valid, tx_end_of_frame, tx_data, pkt_count, drop_count, core_ovf}, '0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_rst", 64'(in_ready), 1);
  endtask

  task automatic write_word(input logic [63:0] d);
    in_valid = 1'b1; in_data = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_pkts(input int n);
    bit done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (pkt_count == 32'(n)) done = 1;
    end
    @(negedge clk);
    chk("pkt_count", 64'(pkt_count), 64'(n));
    chk("sb_drained", 64'(sb.size()), 0);
  endtask

  task automatic wait_word(input logic [63:0] d);
    bit done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (tx_valid && tx_data == d) done = 1;
    end
    if (!done) chk("wait_word_timeout", 0, 1);
  endtask

  initial begin
    int n;
    // 1: single frame
    do_reset();
    enable = 1'b1; dest_ip = 32'hC0A80510; dest_port = 16'd10000;
    exp_frame(48'd0, 64'd1, 32'hC0A80510, 16'd10000);
    for (int i = 1; i <= 4; i++) write_word(64'(i));
    wait_pkts(1);

    // 2: two back-to-back frames, dest change mid-frame hits frame 2 only
    do_reset();
    exp_frame(48'd0, 64'd1, 32'hC0A80510, 16'd10000);
    exp_frame(48'd1, 64'd5, 32'h0A000001, 16'd4321);
    for (int i = 1; i <= 8; i++) write_word(64'(i));
    dest_ip = 32'h0A000001; dest_port = 16'd4321;
    wait_pkts(2);
    chk("eof_to_hdr_gap", 64'(hdr_gap), 2);

    // 3: back-pressure for 3 cycles after payload word 2
    do_reset();
    exp_frame(48'd0, 64'd1, 32'h0A000001, 16'd4321);
    for (int i = 1; i <= 4; i++) write_word(64'(i));
    wait_word(64'd2);
    tx_afull = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx_valid) break;
      n++;
      if (n == 3) tx_afull = 1'b0;
    end
    tx_afull = 1'b0;
    chk("afull_idle_cycles", 64'(n), 3);
    wait_pkts(1);

    // 4: overfill with enable low, then drain
    do_reset();
    enable = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      write_word(64'(i));
      if (i == 8) chk("in_ready_full", 64'(in_ready), 0);
    end
    chk("drop_count", 64'(drop_count), 2);
    chk("no_frame_when_disabled", 64'(pkt_count), 0);
    exp_frame(48'd0, 64'd1, 32'h0A000001, 16'd4321);
    exp_frame(48'd1, 64'd5, 32'h0A000001, 16'd4321);
    enable = 1'b1;
    wait_pkts(2);

    // 5: reset mid-payload
    do_reset();
    exp_frame(48'd0, 64'd1, 32'h0A000001, 16'd4321);
    for (int i = 1; i <= 4; i++) write_word(64'(i));
    wait_word(64'd2);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_tx_valid", 64'(tx_valid), 0);
    chk("rst_mid_pkt_count", 64'(pkt_count), 0);
    do_reset();
    exp_frame(48'd0, 64'h11, 32'h0A000001, 16'd4321);
    for (int i = 0; i < 4; i++) write_word(64'h11 + 64'(i));
    wait_pkts(1);

    // 6: sticky core overflow
    do_reset();
    tx_overflow = 1'b1;
    @(posedge clk); #1;
    tx_overflow = 1'b0;
    chk("core_ovf_set", 64'(core_ovf), 1);
    exp_frame(48'd0, 64'h21, 32'h0A000001, 16'd4321);
    for (int i = 0; i < 4; i++) write_word(64'h21 + 64'(i));
    wait_pkts(1);
    chk("core_ovf_sticky", 64'(core_ovf), 1);
    do_reset();
    chk("core_ovf_cleared", 64'(core_ovf), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
